// File: rtl/led_sequencer.sv
// LED bank controller: a prescaler produces a slow tick that steps the red LEDs through
// the selected pattern; a flash request preempts the pattern and later resumes it.
module led_sequencer #(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned TICK_HZ     = 10,
    parameter int unsigned NLEDS       = 4,
    parameter int unsigned FLASH_TICKS = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_period,
    input  logic             flash_req,
    output logic             busy,
    output logic             step,
    output logic             LED_GRN,
    output logic [NLEDS-1:0] led_red
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FW  = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;

    localparam logic [PW-1:0]    PRESC_MAX  = PW'(DIV - 1);
    localparam logic [FW-1:0]    FLASH_LOAD = FW'(FLASH_TICKS);
    localparam logic [FW-1:0]    FLASH_ONE  = FW'(1);
    localparam logic [NLEDS-1:0] PAT_FIRST  = NLEDS'(1);

    typedef enum logic [1:0] {ModeOff, ModeChase, ModeBounce, ModeBlink} mode_e;
    typedef enum logic [0:0] {StRun, StFlash} state_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [3:0]       period_q, period_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [3:0]       stepcnt_q, stepcnt_d;
    logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
    logic [NLEDS-1:0] pattern_q, pattern_d;
    logic             dir_up_q, dir_up_d;
    logic             step_q, step_d;
    logic             grn_q, grn_d;

    logic tick, accept, advance, onehot, flash_done;

    assign tick       = (presc_q == PRESC_MAX);
    assign accept     = cmd_valid && (state_q == StRun);
    // An accepted command restarts the counters, so a coinciding tick is dropped.
    assign advance    = tick && !accept && (state_q == StRun) && (stepcnt_q == period_q);
    assign onehot     = (pattern_q != '0) && ((pattern_q & (pattern_q - PAT_FIRST)) == '0);
    assign flash_done = !flash_req && tick && (flash_cnt_q <= FLASH_ONE);

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (flash_req)  state_d = StFlash;
            StFlash: if (flash_done) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q == StFlash);
        cmd_ready = (state_q == StRun);
        led_red   = (state_q == StFlash) ? '1 : pattern_q;
        step      = step_q;
        LED_GRN   = grn_q;
    end

    // Datapath next state
    always_comb begin
        presc_d     = (accept || tick) ? '0 : presc_q + PW'(1);
        grn_d       = grn_q ^ (tick && !accept);
        step_d      = advance;
        mode_d      = mode_q;
        period_d    = period_q;
        stepcnt_d   = stepcnt_q;
        pattern_d   = pattern_q;
        dir_up_d    = dir_up_q;
        flash_cnt_d = flash_cnt_q;

        if (accept) begin
            mode_d    = mode_e'(cmd_mode);
            period_d  = cmd_period;
            stepcnt_d = '0;
            dir_up_d  = 1'b1;
            unique case (mode_e'(cmd_mode))
                ModeOff:                pattern_d = '0;
                ModeChase, ModeBounce:  pattern_d = PAT_FIRST;
                ModeBlink:              pattern_d = '1;
                default:                pattern_d = '0;
            endcase
        end else if (tick && (state_q == StRun)) begin
            stepcnt_d = (stepcnt_q == period_q) ? 4'd0 : stepcnt_q + 4'd1;
        end

        if (advance) begin
            unique case (mode_q)
                ModeOff: pattern_d = '0;
                ModeChase: begin
                    if (!onehot) pattern_d = PAT_FIRST;
                    else         pattern_d = {pattern_q[NLEDS-2:0], pattern_q[NLEDS-1]};
                end
                ModeBounce: begin
                    // Reverse at an endpoint so neither end is shown twice.
                    if (!onehot) begin
                        pattern_d = PAT_FIRST;
                        dir_up_d  = 1'b1;
                    end else if (dir_up_q) begin
                        if (pattern_q[NLEDS-1]) begin
                            pattern_d = pattern_q >> 1;
                            dir_up_d  = 1'b0;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            pattern_d = pattern_q << 1;
                            dir_up_d  = 1'b1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                end
                ModeBlink: pattern_d = ~pattern_q;
                default:   pattern_d = '0;
            endcase
        end

        if (flash_req) begin
            flash_cnt_d = FLASH_LOAD;
        end else if ((state_q == StFlash) && tick) begin
            flash_cnt_d = (flash_cnt_q <= FLASH_ONE) ? '0 : flash_cnt_q - FLASH_ONE;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_q      <= ModeOff;
            period_q    <= '0;
            presc_q     <= '0;
            stepcnt_q   <= '0;
            flash_cnt_q <= '0;
            pattern_q   <= '0;
            dir_up_q    <= 1'b1;
            step_q      <= 1'b0;
            grn_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            period_q    <= period_d;
            presc_q     <= presc_d;
            stepcnt_q   <= stepcnt_d;
            flash_cnt_q <= flash_cnt_d;
            pattern_q   <= pattern_d;
            dir_up_q    <= dir_up_d;
            step_q      <= step_d;
            grn_q       <= grn_d;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed scenarios plus random traffic, all compared per cycle
// against an advance-count model of the LED sequencer.
module tb_led_sequencer;

    localparam int DIV = 10;
    localparam int FT  = 3;

    logic       CLK = 1'b0;
    logic       RST_N, cmd_valid, cmd_ready, flash_req, busy, step, LED_GRN;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_period;
    logic [3:0] led_red;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLK = ~CLK;

    led_sequencer #(
        .CLK_HZ     (20),
        .TICK_HZ    (2),
        .NLEDS      (4),
        .FLASH_TICKS(FT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_period(cmd_period),
        .flash_req (flash_req),
        .busy      (busy),
        .step      (step),
        .LED_GRN   (LED_GRN),
        .led_red   (led_red)
    );

    // Model: cycles since prescaler clear, ticks counted in RUN, advances since load.
    int m_mode, m_per, m_mc, m_tk, m_adv, m_left;
    bit m_hb, m_flash, m_step;

    function automatic logic [3:0] pat_of(int mode, int k);
        int idx;
        idx = k % 6;
        case (mode)
            1:       return 4'(1 << (k % 4));
            2:       return (idx < 4) ? 4'(1 << idx) : 4'(1 << (6 - idx));
            3:       return (k % 2 == 0) ? 4'hf : 4'h0;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [7:0] expv();
        return {!m_flash, m_flash, m_step, m_hb, (m_flash ? 4'hf : pat_of(m_mode, m_adv))};
    endfunction

    function automatic logic [7:0] obsv();
        return {cmd_ready, busy, step, LED_GRN, led_red};
    endfunction

    task automatic model_edge();
        bit tk, acc;
        if (!RST_N) begin
            m_mode = 0; m_per = 0; m_mc = 0; m_tk = 0; m_adv = 0; m_left = 0;
            m_hb = 0; m_flash = 0; m_step = 0;
        end else begin
            tk     = (m_mc % DIV) == DIV - 1;
            acc    = cmd_valid && !m_flash;
            m_step = 0;
            if (acc) begin
                m_mode = int'(cmd_mode); m_per = int'(cmd_period);
                m_mc = 0; m_tk = 0; m_adv = 0;
            end else begin
                m_mc++;
                if (tk) begin
                    m_hb = !m_hb;
                    if (!m_flash) begin
                        if (m_tk % (m_per + 1) == m_per) begin
                            m_step = 1;
                            m_adv++;
                        end
                        m_tk++;
                    end
                end
            end
            if (m_flash) begin
                if (flash_req) m_left = FT;
                else if (tk) begin
                    m_left--;
                    if (m_left == 0) m_flash = 0;
                end
            end else if (flash_req) begin
                m_flash = 1;
                m_left  = FT;
            end
        end
    endtask

    // Advance one cycle; outputs are then sampled at the falling edge.
    task automatic clk1();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic issue(input logic [1:0] mode, input logic [3:0] per, input logic fl);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_period = per; flash_req = fl;
        clk1();
        cmd_valid = 1'b0; flash_req = 1'b0;
    endtask

    task automatic test_reset();
        logic prev_g;
        int   toggles;
        RST_N = 1'b0; cmd_valid = 1'b0; flash_req = 1'b0; cmd_mode = '0; cmd_period = '0;
        clk1();
        clk1();
        RST_N = 1'b1;
        n_checks++;
        if (obsv() !== 8'b1000_0000) begin
            n_fails++;
            $display("FAIL reset_state: got %b want %b", obsv(), 8'b1000_0000);
        end
        prev_g  = LED_GRN;
        toggles = 0;
        for (int i = 0; i < 100; i++) begin
            clk1();
            if (LED_GRN !== prev_g) toggles++;
            prev_g = LED_GRN;
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL idle cyc %0d: got %b want %b", i, obsv(), expv());
            end
        end
        n_checks++;
        if (toggles !== 10) begin
            n_fails++;
            $display("FAIL idle_heartbeat: got %0d toggles want 10", toggles);
        end
    endtask

    task automatic test_chase();
        logic [3:0] prev;
        int         changes;
        issue(2'd1, 4'd0, 1'b0);
        n_checks++;
        if (led_red !== 4'b0001 || step !== 1'b0) begin
            n_fails++;
            $display("FAIL chase_load: got led %b step %b want 0001 0", led_red, step);
        end
        prev    = led_red;
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            clk1();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL chase cyc %0d: got %b want %b", i, obsv(), expv());
            end
            n_checks++;
            if ((led_red !== prev) !== step) begin
                n_fails++;
                $display("FAIL chase_step_align cyc %0d: got step %b want %b", i, step,
                         led_red !== prev);
            end
            if (led_red !== prev) changes++;
            prev = led_red;
        end
        n_checks++;
        if (changes !== 4 || led_red !== 4'b0001) begin
            n_fails++;
            $display("FAIL chase_wrap: got %0d changes led %b want 4 changes led 0001",
                     changes, led_red);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seen[$];
        logic [3:0] want[7];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        issue(2'd2, 4'd1, 1'b0);
        seen.push_back(led_red);
        for (int i = 0; i < 120; i++) begin
            clk1();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL bounce cyc %0d: got %b want %b", i, obsv(), expv());
            end
            if (led_red !== seen[$]) seen.push_back(led_red);
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (i >= seen.size() || seen[i] !== want[i]) begin
                n_fails++;
                $display("FAIL bounce_seq[%0d]: got %b want %b", i,
                         (i < seen.size()) ? seen[i] : 4'bx, want[i]);
            end
        end
    endtask

    task automatic test_blink();
        issue(2'd3, 4'd0, 1'b0);
        n_checks++;
        if (led_red !== 4'b1111) begin
            n_fails++;
            $display("FAIL blink_load: got %b want 1111", led_red);
        end
        for (int i = 0; i < 30; i++) begin
            clk1();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL blink cyc %0d: got %b want %b", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_flash();
        bit done;
        issue(2'd1, 4'd0, 1'b0);
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            clk1();
            if (led_red === 4'b0100) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fails++;
            $display("FAIL flash_setup: got led %b want 0100 within 50 cycles", led_red);
        end
        flash_req = 1'b1;
        clk1();
        flash_req = 1'b0;
        n_checks++;
        if ({busy, cmd_ready, led_red} !== 6'b10_1111) begin
            n_fails++;
            $display("FAIL flash_enter: got %b want 101111", {busy, cmd_ready, led_red});
        end
        cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_period = 4'd0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            clk1();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL flash cyc %0d: got %b want %b", i, obsv(), expv());
            end
            if (!busy) done = 1;
        end
        n_checks++;
        if (!done || led_red !== 4'b0100 || cmd_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL flash_exit: got led %b ready %b want 0100 1", led_red, cmd_ready);
        end
        clk1();
        cmd_valid = 1'b0;
        n_checks++;
        if (led_red !== 4'b1111 || obsv() !== expv()) begin
            n_fails++;
            $display("FAIL flash_stalled_cmd: got %b want %b", obsv(), expv());
        end
    endtask

    task automatic test_reset_mid_flash();
        int   ticks;
        bit   prev_busy, prev_g, retrig;
        flash_req = 1'b1;
        clk1();
        flash_req = 1'b0;
        for (int i = 0; i < 15; i++) clk1();
        RST_N = 1'b0;
        clk1();
        RST_N = 1'b1;
        n_checks++;
        if (obsv() !== 8'b1000_0000) begin
            n_fails++;
            $display("FAIL reset_mid_flash: got %b want %b", obsv(), 8'b1000_0000);
        end
        flash_req = 1'b1;
        clk1();
        flash_req = 1'b0;
        ticks  = 0;
        retrig = 0;
        prev_busy = busy;
        prev_g    = LED_GRN;
        for (int i = 0; i < 120 && prev_busy; i++) begin
            clk1();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL retrigger cyc %0d: got %b want %b", i, obsv(), expv());
            end
            if (LED_GRN !== prev_g) ticks++;
            prev_g    = LED_GRN;
            prev_busy = busy;
            flash_req = 1'b0;
            if (ticks == 2 && !retrig) begin
                flash_req = 1'b1;
                retrig    = 1;
            end
        end
        flash_req = 1'b0;
        n_checks++;
        if (ticks !== 5 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL retrigger_len: got %0d ticks busy %b want 5 ticks busy 0",
                     ticks, busy);
        end
    endtask

    task automatic test_back_to_back();
        issue(2'd2, 4'd0, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || led_red !== 4'b1111) begin
            n_fails++;
            $display("FAIL cmd_with_flash: got busy %b led %b want 1 1111", busy, led_red);
        end
        for (int i = 0; i < 50; i++) begin
            clk1();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL b2b cyc %0d: got %b want %b", i, obsv(), expv());
            end
        end
        n_checks++;
        if (led_red !== 4'b0100 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_resume: got led %b busy %b want 0100 0", led_red, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = ($urandom_range(99) < 6);
            cmd_mode   = 2'($urandom_range(3));
            cmd_period = 4'($urandom_range(3));
            flash_req  = ($urandom_range(99) < 2);
            RST_N      = !($urandom_range(999) < 3);
            clk1();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fails++;
                $display("FAIL random cyc %0d: got %b want %b", i, obsv(), expv());
            end
        end
        cmd_valid = 1'b0; flash_req = 1'b0; RST_N = 1'b1;
    endtask

    initial begin
        test_reset();
        test_chase();
        test_bounce();
        test_blink();
        test_flash();
        test_reset_mid_flash();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
